// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter for the RV32I core.
// Instruction fetch (IF) and the load/store unit (LS) share one memory port.
// LS has fixed priority. A saturating starvation counter lets IF win once it
// has been denied MAX_WAIT times. The winner stays locked until memory accepts
// it, and the single outstanding response is routed back to its owner.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    // Instruction fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // Load/store requester
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    // Memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    // Status
    output logic              stall_if,
    output logic              busy,
    output logic              protocol_err
);

    localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    // IDLE: arbitrate and present the winner live.
    // HOLD: winner presented but not yet accepted; request replayed from registers.
    // WAIT: request accepted, waiting for its single response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic               we_q, we_d;
    logic [3:0]         be_q, be_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic               protocol_err_q, protocol_err_d;

    logic               any_req;
    logic               if_wins;
    logic               ls_wins;

    // Fixed-priority selection with the starvation override for IF
    always_comb begin
        any_req = if_req | ls_req;
        if_wins = if_req & (~ls_req | (starve_cnt_q == CNT_MAX));
        ls_wins = ls_req & ~if_wins;
    end

    // Next-state, memory-side drive, grant pulses and response routing
    always_comb begin
        // NOTE: every output and next-state is given a default before the case,
        // so no path through the block can leave a signal unassigned (no latch).
        state_d        = state_q;
        owner_d        = owner_q;
        we_d           = we_q;
        be_d           = be_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        protocol_err_d = protocol_err_q;

        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;

        unique case (state_q)
            IDLE: begin
                mem_req = any_req;
                if (if_wins) begin
                    // Fetches are always full-word reads
                    mem_be   = 4'hF;
                    mem_addr = if_addr;
                end else if (ls_wins) begin
                    mem_we    = ls_we;
                    mem_be    = ls_be;
                    mem_addr  = ls_addr;
                    mem_wdata = ls_wdata;
                end

                // Capture the winner every idle cycle so HOLD can replay it
                owner_d = ls_wins ? OWN_LS : OWN_IF;
                we_d    = mem_we;
                be_d    = mem_be;
                addr_d  = mem_addr;
                wdata_d = mem_wdata;

                if (any_req) begin
                    if (mem_gnt) begin
                        if_gnt  = if_wins;
                        ls_gnt  = ls_wins;
                        state_d = WAIT;
                    end else begin
                        state_d = HOLD;
                    end
                end

                // Nothing is outstanding here, so any response is spurious
                if (mem_rvalid) begin
                    protocol_err_d = 1'b1;
                end
            end

            HOLD: begin
                // Owner is locked; no re-arbitration until memory accepts
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_be    = be_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;

                if (mem_gnt) begin
                    if_gnt  = (owner_q == OWN_IF);
                    ls_gnt  = (owner_q == OWN_LS);
                    state_d = WAIT;
                end

                if (mem_rvalid) begin
                    protocol_err_d = 1'b1;
                end
            end

            WAIT: begin
                if (mem_rvalid) begin
                    if (owner_q == OWN_IF) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end else begin
                        ls_rvalid = 1'b1;
                        ls_rdata  = mem_rdata;
                    end
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Starvation counter: counts denied IF cycles, saturates, clears on grant
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt) begin
            starve_cnt_d = '0;
        end else if (if_req && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // State, captured request, counter and sticky error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the capture registers are reset as well. They are only a few
            // flops, and this keeps mem_* free of X after reset in any state.
            state_q        <= IDLE;
            owner_q        <= OWN_IF;
            we_q           <= 1'b0;
            be_q           <= 4'h0;
            addr_q         <= '0;
            wdata_q        <= '0;
            starve_cnt_q   <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge values no matter what order these statements are in.
            state_q        <= state_d;
            owner_q        <= owner_d;
            we_q           <= we_d;
            be_q           <= be_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            starve_cnt_q   <= starve_cnt_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign stall_if     = if_req & ~if_gnt;
    assign busy         = (state_q != IDLE);
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// A transaction-level reference model predicts grants, responses and status.
// The predictions go into queues, and a monitor compares them against the DUT
// on the falling clock edge.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    localparam int NONE = 0;
    localparam int IFR  = 1;
    localparam int LSR  = 2;

    typedef struct {
        int          owner;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        int          owner;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        bit          mreq;
        bit          chk_addr;
        logic [31:0] addr;
        bit          busy;
        bit          stall;
        bit          perr;
        int          gnt;
    } st_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req = 1'b0;
    logic              ls_we = 1'b0;
    logic [3:0]        ls_be = 4'h0;
    logic [ADDR_W-1:0] ls_addr = '0;
    logic [DATA_W-1:0] ls_wdata = '0;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              stall_if;
    logic              busy;
    logic              protocol_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_be       (ls_be),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_gnt      (ls_gnt),
        .ls_rvalid   (ls_rvalid),
        .ls_rdata    (ls_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .stall_if    (stall_if),
        .busy        (busy),
        .protocol_err(protocol_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    gnt_t exp_gnt_q[$];
    rsp_t exp_rsp_q[$];
    st_t  exp_st_q[$];

    // Reference model: is a transaction open, who owns it, who is locked
    // waiting for acceptance, and how long IF has been denied.
    bit          mdl_out = 1'b0;
    int          mdl_owner = NONE;
    int          mdl_locked = NONE;
    int          mdl_starve = 0;
    bit          mdl_perr = 1'b0;
    int          last_grant = NONE;

    // Memory agent: one pending response with a countdown
    int          rsp_cnt = 0;
    logic [31:0] rsp_data = '0;
    bit          fix_rsp = 1'b0;
    int          fix_delay = 1;
    logic [31:0] fix_data = '0;

    // Requester agents: a request is held until the model says it was granted
    bit          ifa_req = 1'b0;
    logic [31:0] ifa_addr = '0;
    bit          lsa_req = 1'b0;
    bit          lsa_we = 1'b0;
    logic [3:0]  lsa_be = 4'h0;
    logic [31:0] lsa_addr = '0;
    logic [31:0] lsa_wdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive the inputs, advance the model, queue expectations
    task automatic step(input bit gnt);
        bit   rv;
        int   cand;
        st_t  s;
        gnt_t g;
        rsp_t r;
        @(posedge clk);
        #1;
        rv = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            rv = (rsp_cnt == 0);
        end
        // NOTE: inputs are driven with blocking assignments 1 ns after the
        // rising edge, so the DUT never sees them change on its sampling edge.
        if_req     = ifa_req;
        if_addr    = ifa_addr;
        ls_req     = lsa_req;
        ls_we      = lsa_we;
        ls_be      = lsa_be;
        ls_addr    = lsa_addr;
        ls_wdata   = lsa_wdata;
        mem_gnt    = gnt;
        mem_rvalid = rv;
        mem_rdata  = rv ? rsp_data : $urandom;

        s.busy     = mdl_out || (mdl_locked != NONE);
        s.perr     = mdl_perr;
        s.mreq     = 1'b0;
        s.chk_addr = 1'b0;
        s.addr     = '0;
        last_grant = NONE;

        if (mdl_out) begin
            if (rv) begin
                r.owner = mdl_owner;
                r.data  = rsp_data;
                exp_rsp_q.push_back(r);
                mdl_out = 1'b0;
            end
        end else begin
            cand = mdl_locked;
            if (cand == NONE) begin
                if (ifa_req && (!lsa_req || mdl_starve == MAX_WAIT)) cand = IFR;
                else if (lsa_req) cand = LSR;
            end
            s.mreq     = (cand != NONE);
            s.chk_addr = 1'b1;
            s.addr     = (cand == IFR) ? ifa_addr : (cand == LSR) ? lsa_addr : 32'h0;
            if (rv) mdl_perr = 1'b1;
            if (cand != NONE && gnt) begin
                last_grant = cand;
                mdl_out    = 1'b1;
                mdl_owner  = cand;
                mdl_locked = NONE;
                g.owner = cand;
                g.we    = (cand == LSR) && lsa_we;
                g.be    = (cand == LSR) ? lsa_be : 4'hF;
                g.addr  = s.addr;
                g.wdata = (cand == LSR) ? lsa_wdata : 32'h0;
                exp_gnt_q.push_back(g);
                rsp_cnt  = fix_rsp ? fix_delay : int'($urandom_range(3, 1));
                rsp_data = fix_rsp ? fix_data : $urandom;
            end else begin
                mdl_locked = cand;
            end
        end

        s.stall = ifa_req && (last_grant != IFR);
        s.gnt   = last_grant;
        if (last_grant == IFR) mdl_starve = 0;
        else if (ifa_req && mdl_starve < MAX_WAIT) mdl_starve++;
        exp_st_q.push_back(s);

        if (last_grant == IFR) ifa_req = 1'b0;
        if (last_grant == LSR) lsa_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        ifa_req    = 1'b0;
        lsa_req    = 1'b0;
        if_req     = 1'b0;
        ls_req     = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mdl_out    = 1'b0;
        mdl_owner  = NONE;
        mdl_locked = NONE;
        mdl_starve = 0;
        mdl_perr   = 1'b0;
        @(negedge clk);
        check("rst_mem_req",  64'(mem_req), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_be",   64'(mem_be), 64'(0));
        check("rst_gnt",      64'({if_gnt, ls_gnt}), 64'(0));
        check("rst_rvalid",   64'({if_rvalid, ls_rvalid}), 64'(0));
        check("rst_stall_if", 64'(stall_if), 64'(0));
        check("rst_busy",     64'(busy), 64'(0));
        check("rst_perr",     64'(protocol_err), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic rand_phase(input int n, input int if_pct, input int ls_pct, input int gnt_pct);
        for (int i = 0; i < n; i++) begin
            if (!ifa_req && int'($urandom_range(99)) < if_pct) begin
                ifa_req  = 1'b1;
                ifa_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsa_req && int'($urandom_range(99)) < ls_pct) begin
                lsa_req   = 1'b1;
                lsa_we    = 1'($urandom_range(1));
                lsa_be    = 4'($urandom_range(15, 1));
                lsa_addr  = $urandom & 32'hFFFF_FFFC;
                lsa_wdata = $urandom;
            end
            step(int'($urandom_range(99)) < gnt_pct);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (ifa_req || lsa_req || mdl_out || rsp_cnt > 0); i++) begin
            step(1'b1);
        end
    endtask

    // Monitor: compares the DUT against queued expectations every cycle
    initial begin : monitor
        st_t  s;
        gnt_t g;
        rsp_t r;
        int   own;
        forever begin
            @(negedge clk);
            if (exp_st_q.size() > 0) begin
                s = exp_st_q.pop_front();
                check("mem_req", 64'(mem_req), 64'(s.mreq));
                if (s.chk_addr) check("mem_addr", 64'(mem_addr), 64'(s.addr));
                check("busy", 64'(busy), 64'(s.busy));
                check("stall_if", 64'(stall_if), 64'(s.stall));
                check("protocol_err", 64'(protocol_err), 64'(s.perr));
                check("gnt_pulse", 64'({if_gnt, ls_gnt}),
                      64'((s.gnt == IFR) ? 2'b10 : (s.gnt == LSR) ? 2'b01 : 2'b00));
            end
            if (if_gnt || ls_gnt) begin
                own = (if_gnt && ls_gnt) ? 3 : (if_gnt ? IFR : LSR);
                if (exp_gnt_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_gnt: actual owner=%0d required none at %0t", own, $time);
                end else begin
                    g = exp_gnt_q.pop_front();
                    check("gnt_owner", 64'(own), 64'(g.owner));
                    check("gnt_mem_we", 64'(mem_we), 64'(g.we));
                    check("gnt_mem_be", 64'(mem_be), 64'(g.be));
                    check("gnt_mem_addr", 64'(mem_addr), 64'(g.addr));
                    check("gnt_mem_wdata", 64'(mem_wdata), 64'(g.wdata));
                end
            end
            if (if_rvalid || ls_rvalid) begin
                own = (if_rvalid && ls_rvalid) ? 3 : (if_rvalid ? IFR : LSR);
                if (exp_rsp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rvalid: actual owner=%0d required none at %0t", own, $time);
                end else begin
                    r = exp_rsp_q.pop_front();
                    check("rsp_owner", 64'(own), 64'(r.owner));
                    check("rsp_rdata", 64'(if_rvalid ? if_rdata : ls_rdata), 64'(r.data));
                end
            end
            if (!if_rvalid) check("if_rdata_zero", 64'(if_rdata), 64'(0));
            if (!ls_rvalid) check("ls_rdata_zero", 64'(ls_rdata), 64'(0));
        end
    end

    initial begin : stimulus
        do_reset();

        // Single fetch: granted immediately, data back two cycles later
        ifa_req  = 1'b1;
        ifa_addr = 32'h0000_0100;
        fix_rsp  = 1'b1;
        fix_delay = 2;
        fix_data = 32'h0050_0093;
        step(1'b1);
        repeat (3) step(1'b0);

        // Collision: LS store wins, IF follows after the store ack
        ifa_req   = 1'b1;
        ifa_addr  = 32'h0000_0200;
        lsa_req   = 1'b1;
        lsa_we    = 1'b1;
        lsa_be    = 4'b0011;
        lsa_addr  = 32'h0000_2000;
        lsa_wdata = 32'hDEAD_BEEF;
        fix_data  = 32'h0000_0000;
        repeat (6) step(1'b1);
        fix_rsp = 1'b0;
        drain();

        // Hold lock: IF waits in HOLD while LS arrives; owner must not switch
        ifa_req  = 1'b1;
        ifa_addr = 32'h0000_0300;
        step(1'b0);
        lsa_req   = 1'b1;
        lsa_we    = 1'b0;
        lsa_be    = 4'hF;
        lsa_addr  = 32'h0000_0400;
        lsa_wdata = 32'h0;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        drain();

        // Random mixes, including continuous LS pressure to exercise starvation
        rand_phase(200, 40, 40, 60);
        rand_phase(80, 100, 100, 100);
        rand_phase(80, 100, 100, 40);
        rand_phase(150, 20, 70, 80);
        drain();

        // Back-to-back loads, response one cycle after grant, IF idle
        fix_rsp   = 1'b1;
        fix_delay = 1;
        for (int k = 0; k < 4; k++) begin
            lsa_req   = 1'b1;
            lsa_we    = 1'b0;
            lsa_be    = 4'hF;
            lsa_addr  = 32'h0000_1000 + 32'(4 * k);
            lsa_wdata = 32'h0;
            fix_data  = 32'hA5A5_0000 + 32'(k);
            step(1'b1);
            step(1'b0);
        end

        // Reset in WAIT: the dropped response arrives afterwards and is flagged
        lsa_req   = 1'b1;
        lsa_we    = 1'b0;
        lsa_addr  = 32'h0000_0500;
        fix_delay = 3;
        fix_data  = 32'h1234_5678;
        step(1'b1);
        step(1'b0);
        fix_rsp = 1'b0;
        do_reset();
        repeat (5) step(1'b0);
        rand_phase(100, 40, 40, 70);
        drain();
        do_reset();
        rand_phase(60, 50, 50, 70);
        drain();

        @(posedge clk);
        @(negedge clk);
        check("gnt_queue_empty", 64'(exp_gnt_q.size()), 64'(0));
        check("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
